regfile_fwd: RTL and testbench

- General-purpose register file that answers the decode stage's two read requests (enable plus address) and returns the operand data that decode consumes.
- Resolves data hazards in the same block:
  - forwards results from the EX, MEM and WB stages;
  - tracks in-flight multi-cycle GPR writers in a pending-bit scoreboard;
  - raises a stall request when an operand is not yet available.

---
 rtl/regfile_fwd_pkg.sv | 22 ++
 rtl/regfile_fwd_port.sv | 56 +++++
 rtl/regfile_fwd.sv | 122 ++++++++++++
 tb/tb_regfile_fwd.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared encodings and widths for the register file with operand forwarding
// and the pending-writer scoreboard.
package regfile_fwd_pkg;

    localparam logic RstEnable    = 1'b0;
    localparam logic RstDisable   = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam int CntW       = 6;

    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic [RegBus-1:0]     ZeroWord   = '0;

endpackage

// File: rtl/regfile_fwd_port.sv
// One decode read port: EX > MEM > WB > array forwarding priority, plus the
// load-use and pending-operand stall detect for that port.
module regfile_fwd_port
    import regfile_fwd_pkg::*;
#(
    parameter int REG_AW = RegAddrBus,
    parameter int DATA_W = RegBus
) (
    input  logic              rst,
    input  logic              re,
    input  logic [REG_AW-1:0] raddr,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_load,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              pend_bit,
    output logic [DATA_W-1:0] rdata,
    output logic              stall
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic active;

    assign active  = (rst != RstEnable) && (re == ReadEnable) && (raddr != '0);
    assign ex_hit  = ex_wreg  && (ex_wd  == raddr);
    assign mem_hit = mem_wreg && (mem_wd == raddr);
    assign wb_hit  = (we == WriteEnable) && (waddr == raddr);

    always_comb begin
        rdata = '0;
        stall = NoStop;
        if (active) begin
            if (ex_hit)
                rdata = ex_wdata;
            else if (mem_hit)
                rdata = mem_wdata;
            else if (wb_hit)
                rdata = wdata;
            else
                rdata = reg_data;
            // a same-cycle WB of a pending register still stalls this cycle
            if ((ex_hit && ex_load) || pend_bit)
                stall = Stop;
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// GPR file with EX/MEM/WB forwarding and a pending-bit scoreboard for
// multi-cycle writers; raises stall_req_o when an operand is not yet ready.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int REG_NUM = RegNum,
    parameter int REG_AW  = RegAddrBus,
    parameter int DATA_W  = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_wd_i,
    output logic              stall_req_o,
    output logic [CntW-1:0]   pend_cnt_o
);

    logic [DATA_W-1:0]  regs [REG_NUM];
    logic [REG_NUM-1:0] pend;
    logic [REG_NUM-1:0] pend_next;
    logic [CntW-1:0]    pend_cnt;
    logic               set_v;
    logic               clr_v;
    logic               inc;
    logic               dec;
    logic               stall1;
    logic               stall2;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++)
                regs[i] <= '0;
        end else if (we_i == WriteEnable && waddr_i != '0) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign set_v = issue_i && (issue_wd_i != '0);
    assign clr_v = (we_i == WriteEnable) && pend[waddr_i];
    assign inc   = set_v && !pend[issue_wd_i];
    // clearing a bit that is re-set in the same cycle leaves the count alone
    assign dec   = clr_v && !(set_v && (issue_wd_i == waddr_i));

    always_comb begin
        pend_next = pend;
        if (clr_v)
            pend_next[waddr_i] = 1'b0;
        if (set_v)
            pend_next[issue_wd_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= pend_cnt + CntW'(inc) - CntW'(dec);
        end
    end

    assign pend_cnt_o = pend_cnt;

    regfile_fwd_port #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_port1 (
        .rst       (rst),
        .re        (re1_i),
        .raddr     (raddr1_i),
        .ex_wreg   (ex_wreg_i),
        .ex_wd     (ex_wd_i),
        .ex_wdata  (ex_wdata_i),
        .ex_load   (ex_load_i),
        .mem_wreg  (mem_wreg_i),
        .mem_wd    (mem_wd_i),
        .mem_wdata (mem_wdata_i),
        .we        (we_i),
        .waddr     (waddr_i),
        .wdata     (wdata_i),
        .reg_data  (regs[raddr1_i]),
        .pend_bit  (pend[raddr1_i]),
        .rdata     (rdata1_o),
        .stall     (stall1)
    );

    regfile_fwd_port #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_port2 (
        .rst       (rst),
        .re        (re2_i),
        .raddr     (raddr2_i),
        .ex_wreg   (ex_wreg_i),
        .ex_wd     (ex_wd_i),
        .ex_wdata  (ex_wdata_i),
        .ex_load   (ex_load_i),
        .mem_wreg  (mem_wreg_i),
        .mem_wd    (mem_wd_i),
        .mem_wdata (mem_wdata_i),
        .we        (we_i),
        .waddr     (waddr_i),
        .wdata     (wdata_i),
        .reg_data  (regs[raddr2_i]),
        .pend_bit  (pend[raddr2_i]),
        .rdata     (rdata2_o),
        .stall     (stall2)
    );

    assign stall_req_o = stall1 || stall2;

endmodule

// File: tb/tb_regfile_fwd.sv
// Bench for regfile_fwd: directed test-plan sequence with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        re1_i = 1'b0;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic        re2_i = 1'b0;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;
    logic        ex_wreg_i = 1'b0;
    logic [4:0]  ex_wd_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic        ex_load_i = 1'b0;
    logic        mem_wreg_i = 1'b0;
    logic [4:0]  mem_wd_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        issue_i = 1'b0;
    logic [4:0]  issue_wd_i = '0;
    logic        stall_req_o;
    logic [5:0]  pend_cnt_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    regfile_fwd dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .re1_i       (re1_i),
        .raddr1_i    (raddr1_i),
        .rdata1_o    (rdata1_o),
        .re2_i       (re2_i),
        .raddr2_i    (raddr2_i),
        .rdata2_o    (rdata2_o),
        .ex_wreg_i   (ex_wreg_i),
        .ex_wd_i     (ex_wd_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_load_i   (ex_load_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_wd_i    (mem_wd_i),
        .mem_wdata_i (mem_wdata_i),
        .issue_i     (issue_i),
        .issue_wd_i  (issue_wd_i),
        .stall_req_o (stall_req_o),
        .pend_cnt_o  (pend_cnt_o)
    );

    // Model state: architectural registers and the set of pending registers.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            bit was_pending;
            was_pending = (waddr_i != 0) && m_pend[waddr_i];
            if (we_i && waddr_i != 0)
                m_regs[waddr_i] = wdata_i;
            if (we_i && was_pending)
                m_pend[waddr_i] = 1'b0;
            if (issue_i && issue_wd_i != 0)
                m_pend[issue_wd_i] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 0) return 32'h0;
        if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
        if (we_i && waddr_i == a) return wdata_i;
        return m_regs[a];
    endfunction

    function automatic bit port_blocked(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 0) return 1'b0;
        return (ex_wreg_i && ex_load_i && ex_wd_i == a) || m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] e1, e2;
            bit es;
            int ec;
            e1 = exp_rdata(re1_i, raddr1_i);
            e2 = exp_rdata(re2_i, raddr2_i);
            es = port_blocked(re1_i, raddr1_i) || port_blocked(re2_i, raddr2_i);
            ec = exp_cnt();
            checks += 4;
            if (rdata1_o !== e1) begin
                errors++;
                $display("FAIL model_rdata1 t=%0t got %h want %h", $time, rdata1_o, e1);
            end
            if (rdata2_o !== e2) begin
                errors++;
                $display("FAIL model_rdata2 t=%0t got %h want %h", $time, rdata2_o, e2);
            end
            if (stall_req_o !== es) begin
                errors++;
                $display("FAIL model_stall t=%0t got %b want %b", $time, stall_req_o, es);
            end
            if (int'(pend_cnt_o) != ec) begin
                errors++;
                $display("FAIL model_pend_cnt t=%0t got %0d want %0d", $time, pend_cnt_o, ec);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic idle();
        we_i = 0; waddr_i = 0; wdata_i = 0;
        re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
        issue_i = 0; issue_wd_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        cmp_en = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b1;

        re1_i = 1; raddr1_i = 5; re2_i = 1; raddr2_i = 5;
        sample_point();
        lit("reset_rdata1", rdata1_o, 32'h0);
        lit("reset_rdata2", rdata2_o, 32'h0);
        lit("reset_stall", 32'(stall_req_o), 32'h0);
        lit("reset_cnt", 32'(pend_cnt_o), 32'h0);

        next_cycle();
        idle();
        we_i = 1; waddr_i = 3; wdata_i = 32'h1234_5678; re1_i = 1; raddr1_i = 3;
        sample_point();
        lit("wb_bypass_r3", rdata1_o, 32'h1234_5678);
        next_cycle();
        we_i = 0;
        sample_point();
        lit("array_r3", rdata1_o, 32'h1234_5678);
        next_cycle();
        we_i = 1; waddr_i = 0; wdata_i = 32'hFFFF_FFFF; raddr1_i = 0;
        next_cycle();
        we_i = 0;
        sample_point();
        lit("r0_reads_zero", rdata1_o, 32'h0);

        next_cycle();
        idle();
        re1_i = 1; raddr1_i = 4;
        ex_wreg_i = 1; ex_wd_i = 4; ex_wdata_i = 32'hA;
        mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'hB;
        we_i = 1; waddr_i = 4; wdata_i = 32'hC;
        sample_point();
        lit("prio_ex", rdata1_o, 32'hA);
        next_cycle();
        ex_wreg_i = 0;
        sample_point();
        lit("prio_mem", rdata1_o, 32'hB);
        next_cycle();
        mem_wreg_i = 0;
        sample_point();
        lit("prio_wb", rdata1_o, 32'hC);

        next_cycle();
        idle();
        ex_wreg_i = 1; ex_wd_i = 7; ex_load_i = 1; ex_wdata_i = 32'h77;
        re2_i = 1; raddr2_i = 7;
        sample_point();
        lit("load_use_stall", 32'(stall_req_o), 32'h1);
        next_cycle();
        re2_i = 0; re1_i = 1; raddr1_i = 8;
        sample_point();
        lit("load_other_no_stall", 32'(stall_req_o), 32'h0);

        next_cycle();
        idle();
        issue_i = 1; issue_wd_i = 9;
        next_cycle();
        issue_i = 0; re1_i = 1; raddr1_i = 9;
        sample_point();
        lit("issue_cnt1", 32'(pend_cnt_o), 32'h1);
        lit("pend_stall", 32'(stall_req_o), 32'h1);
        next_cycle();
        we_i = 1; waddr_i = 9; wdata_i = 32'h55;
        sample_point();
        lit("wb_same_cycle_stall", 32'(stall_req_o), 32'h1);
        next_cycle();
        we_i = 0;
        sample_point();
        lit("cleared_cnt0", 32'(pend_cnt_o), 32'h0);
        lit("cleared_no_stall", 32'(stall_req_o), 32'h0);
        lit("cleared_r9", rdata1_o, 32'h55);
        next_cycle();
        issue_i = 1; issue_wd_i = 9;
        next_cycle();
        we_i = 1; waddr_i = 9; wdata_i = 32'h66;
        next_cycle();
        issue_i = 0; we_i = 0;
        sample_point();
        lit("set_wins_cnt", 32'(pend_cnt_o), 32'h1);
        lit("set_wins_stall", 32'(stall_req_o), 32'h1);
        next_cycle();
        we_i = 1; waddr_i = 9; wdata_i = 32'h67;
        next_cycle();
        we_i = 0;

        idle();
        issue_i = 1; issue_wd_i = 10;
        next_cycle();
        issue_wd_i = 11;
        next_cycle();
        issue_i = 0;
        sample_point();
        lit("two_pending", 32'(pend_cnt_o), 32'h2);
        next_cycle();
        rst = 1'b0;
        #1;
        lit("rst_cnt_immediate", 32'(pend_cnt_o), 32'h0);
        next_cycle();
        rst = 1'b1;
        re1_i = 1; raddr1_i = 3; re2_i = 1; raddr2_i = 9;
        sample_point();
        lit("after_rst_r3", rdata1_o, 32'h0);
        lit("after_rst_r9", rdata2_o, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst         = ($urandom_range(0, 199) != 0);
            we_i        = $urandom_range(0, 1);
            waddr_i     = 5'($urandom_range(0, 7));
            wdata_i     = $urandom;
            re1_i       = ($urandom_range(0, 7) != 0);
            raddr1_i    = 5'($urandom_range(0, 7));
            re2_i       = ($urandom_range(0, 7) != 0);
            raddr2_i    = 5'($urandom_range(0, 7));
            ex_wreg_i   = ($urandom_range(0, 2) == 0);
            ex_wd_i     = 5'($urandom_range(0, 7));
            ex_wdata_i  = $urandom;
            ex_load_i   = ($urandom_range(0, 2) == 0);
            mem_wreg_i  = ($urandom_range(0, 2) == 0);
            mem_wd_i    = 5'($urandom_range(0, 7));
            mem_wdata_i = $urandom;
            issue_i     = ($urandom_range(0, 2) == 0);
            issue_wd_i  = 5'($urandom_range(0, 31) < 4 ? $urandom_range(0, 31) : $urandom_range(0, 7));
        end
        next_cycle();
        idle();
        rst = 1'b1;
        sample_point();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
